// File: rtl/victim_buffer_nway_pkg.sv
// Shared cache definitions for the victim buffer: sizing defaults,
// the entry tag record and the controller state encoding.
package victim_buffer_nway_pkg;

   localparam int VICTIM_NUM_ENTRIES = 4;
   localparam int VICTIM_ADDR_BITS   = 28;

   typedef struct packed {
      logic                        valid;
      logic                        dirty;
      logic [VICTIM_ADDR_BITS-1:0] addr;
   } type_victim_entry_s;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WB_WAIT,
      ST_FLUSH_SCAN,
      ST_FLUSH_WB,
      ST_FLUSH_DONE
   } type_victim_state_e;

endpackage

// File: rtl/victim_buffer_nway_replace_sel.sv
// Insert slot chooser: same-address entry, swapped-out slot,
// lowest free slot, then the round-robin victim.
module victim_replace_sel #(
   parameter int NUM_ENTRIES = 4,
   parameter int IW          = $clog2(NUM_ENTRIES)
) (
   input  logic [NUM_ENTRIES-1:0] valid,
   input  logic [NUM_ENTRIES-1:0] dirty,
   input  logic [NUM_ENTRIES-1:0] match,
   input  logic                   take,
   input  logic [IW-1:0]          take_slot,
   input  logic [IW-1:0]          rr_ptr,
   output logic [IW-1:0]          slot,
   output logic                   use_rr,
   output logic                   displace
);

   logic [IW-1:0] match_slot;
   logic [IW-1:0] free_slot;

   always_comb begin
      match_slot = '0;
      free_slot  = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (match[i]) match_slot = IW'(i);
         if (!valid[i]) free_slot = IW'(i);
      end
      slot   = rr_ptr;
      use_rr = 1'b0;
      if (|match) slot = match_slot;
      else if (take) slot = take_slot;
      else if (!(&valid)) slot = free_slot;
      else use_rr = 1'b1;
      displace = use_rr && valid[rr_ptr] && dirty[rr_ptr];
   end

endmodule

// File: rtl/victim_buffer_nway.sv
// Fully-associative write-back victim buffer with swap-on-hit,
// round-robin replacement and a sequenced flush.
module victim_buffer_nway
   import victim_buffer_nway_pkg::*;
#(
   parameter int NUM_ENTRIES = VICTIM_NUM_ENTRIES,
   parameter int LINE_WIDTH  = 128,
   parameter int ADDR_BITS   = VICTIM_ADDR_BITS
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               lookup_req_i,
   input  logic [ADDR_BITS-1:0]               lookup_addr_i,
   output logic                               lookup_hit_o,
   output logic [LINE_WIDTH-1:0]              lookup_data_o,
   output logic                               lookup_dirty_o,
   input  logic                               take_i,
   input  logic                               insert_req_i,
   input  logic [ADDR_BITS-1:0]               insert_addr_i,
   input  logic [LINE_WIDTH-1:0]              insert_data_i,
   input  logic                               insert_dirty_i,
   output logic                               insert_ready_o,
   output logic                               wb_valid_o,
   input  logic                               wb_ready_i,
   output logic [ADDR_BITS-1:0]               wb_addr_o,
   output logic [LINE_WIDTH-1:0]              wb_data_o,
   input  logic                               flush_i,
   output logic                               flush_done_o,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy_o
);

   localparam int IW = $clog2(NUM_ENTRIES);
   localparam int OW = $clog2(NUM_ENTRIES + 1);

   type_victim_state_e state_q, state_d;

   logic [NUM_ENTRIES-1:0] valid_q, valid_d;
   logic [NUM_ENTRIES-1:0] dirty_q, dirty_d;
   logic [ADDR_BITS-1:0]   addr_q [NUM_ENTRIES];
   logic [LINE_WIDTH-1:0]  line_q [NUM_ENTRIES];
   logic [IW-1:0]          rr_q, rr_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   pend_q, pend_d;
   logic [ADDR_BITS-1:0]   wb_addr_q;
   logic [LINE_WIDTH-1:0]  wb_data_q;
   logic                   hit_q, hit_dirty_q, hit_ent_q;
   logic [LINE_WIDTH-1:0]  hit_data_q;
   logic [IW-1:0]          hit_slot_q;
   logic [OW-1:0]          occ_q;

   logic [NUM_ENTRIES-1:0] lk_match, ins_match;
   logic [IW-1:0]          lk_slot, sel_slot;
   logic lk_any, wb_hit, take_en, ins_fire;
   logic use_rr, displace, cur_dirty, last;
   logic adv, flush_hs, flush_end;

   always_comb begin
      lk_match  = '0;
      ins_match = '0;
      lk_slot   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         lk_match[i]  = valid_q[i] && addr_q[i] == lookup_addr_i;
         ins_match[i] = valid_q[i] && addr_q[i] == insert_addr_i;
         if (lk_match[i]) lk_slot = IW'(i);
      end
   end

   assign lk_any         = |lk_match;
   assign wb_hit         = state_q == ST_WB_WAIT &&
                           wb_addr_q == lookup_addr_i;
   assign take_en        = take_i && hit_ent_q;
   assign insert_ready_o = state_q == ST_IDLE && !flush_i;
   assign ins_fire       = insert_req_i && insert_ready_o;
   assign cur_dirty      = valid_q[idx_q] && dirty_q[idx_q];
   assign last           = idx_q == IW'(NUM_ENTRIES - 1);

   victim_replace_sel #(
      .NUM_ENTRIES(NUM_ENTRIES),
      .IW         (IW)
   ) u_sel (
      .valid    (valid_q),
      .dirty    (dirty_q),
      .match    (ins_match),
      .take     (take_en),
      .take_slot(hit_slot_q),
      .rr_ptr   (rr_q),
      .slot     (sel_slot),
      .use_rr   (use_rr),
      .displace (displace)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rr_d       = rr_q;
      pend_d     = pend_q | flush_i;
      adv        = 1'b0;
      flush_hs   = 1'b0;
      flush_end  = 1'b0;
      wb_valid_o = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ins_fire && displace) begin
               state_d = ST_WB_WAIT;
            end else if (pend_q) begin
               state_d = ST_FLUSH_SCAN;
               idx_d   = '0;
               pend_d  = flush_i;
            end
         end
         ST_WB_WAIT: begin
            wb_valid_o = 1'b1;
            if (wb_ready_i && pend_q) begin
               state_d = ST_FLUSH_SCAN;
               idx_d   = '0;
               pend_d  = flush_i;
            end else if (wb_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_FLUSH_SCAN: begin
            // dirty entries are offered straight from the scan slot
            wb_valid_o = cur_dirty;
            flush_hs   = cur_dirty && wb_ready_i;
            adv        = !cur_dirty || wb_ready_i;
            if (!adv) state_d = ST_FLUSH_WB;
         end
         ST_FLUSH_WB: begin
            wb_valid_o = 1'b1;
            flush_hs   = wb_ready_i;
            adv        = wb_ready_i;
         end
         ST_FLUSH_DONE: state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
      if (adv && last) begin
         flush_end = 1'b1;
         state_d   = ST_FLUSH_DONE;
         rr_d      = '0;
      end else if (adv) begin
         idx_d   = idx_q + 1'b1;
         state_d = ST_FLUSH_SCAN;
      end
      if (ins_fire && use_rr) rr_d = rr_q + 1'b1;
   end

   always_comb begin
      wb_addr_o = '0;
      wb_data_o = '0;
      if (state_q == ST_WB_WAIT) begin
         wb_addr_o = wb_addr_q;
         wb_data_o = wb_data_q;
      end else if (wb_valid_o) begin
         wb_addr_o = addr_q[idx_q];
         wb_data_o = line_q[idx_q];
      end
   end

   // take clears first so an insert into the swapped slot wins
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (take_en) begin
         valid_d[hit_slot_q] = 1'b0;
         dirty_d[hit_slot_q] = 1'b0;
      end
      if (flush_hs) dirty_d[idx_q] = 1'b0;
      if (ins_fire) begin
         dirty_d[sel_slot] = insert_dirty_i |
                             (|ins_match && dirty_d[sel_slot]);
         valid_d[sel_slot] = 1'b1;
      end
      if (flush_end) begin
         valid_d = '0;
         dirty_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         addr_q      <= '{default: '0};
         rr_q        <= '0;
         idx_q       <= '0;
         pend_q      <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         hit_q       <= 1'b0;
         hit_dirty_q <= 1'b0;
         hit_ent_q   <= 1'b0;
         hit_data_q  <= '0;
         hit_slot_q  <= '0;
         occ_q       <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         rr_q    <= rr_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         occ_q   <= OW'($countones(valid_d));
         if (ins_fire) addr_q[sel_slot] <= insert_addr_i;
         if (ins_fire && displace) begin
            wb_addr_q <= addr_q[sel_slot];
            wb_data_q <= line_q[sel_slot];
         end
         hit_q       <= lookup_req_i && (lk_any || wb_hit);
         hit_dirty_q <= lookup_req_i && lk_any && dirty_q[lk_slot];
         hit_ent_q   <= lookup_req_i && lk_any &&
                        !(ins_fire && sel_slot == lk_slot);
         hit_slot_q  <= lk_slot;
         if (lookup_req_i && lk_any) begin
            hit_data_q <= line_q[lk_slot];
         end else if (lookup_req_i && wb_hit) begin
            hit_data_q <= wb_data_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ins_fire) line_q[sel_slot] <= insert_data_i;
   end

   assign lookup_hit_o   = hit_q;
   assign lookup_data_o  = hit_data_q;
   assign lookup_dirty_o = hit_dirty_q;
   assign flush_done_o   = state_q == ST_FLUSH_DONE;
   assign occupancy_o    = occ_q;

endmodule

// File: doc/victim_buffer_nway.md
# victim_buffer_nway

Parametrised, fully-associative write-back victim buffer between the data-cache datapath and memory. It holds NUM_ENTRIES evicted lines with per-entry dirty state. Lookups return a registered hit, data and dirty one cycle after the request. The buffer supports swap-on-hit, round-robin replacement, a valid/ready write-back port for dirty lines it displaces, and a full flush sequence.

## Interface
Parameters:
- NUM_ENTRIES, 4: number of lines; power of two, 2..16.
- LINE_WIDTH, 128: bits per cache line.
- ADDR_BITS, 28: line address width ({tag, index}, offset excluded).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- lookup_req_i  in  1  lookup strobe.
- lookup_addr_i  in  ADDR_BITS  line address to look up.
- lookup_hit_o  out  1  registered hit, valid the cycle after lookup_req_i.
- lookup_data_o  out  LINE_WIDTH  registered line data of the hit.
- lookup_dirty_o  out  1  registered dirty flag of the hit.
- take_i  in  1  consume (invalidate) the entry that just hit.
- insert_req_i  in  1  insert strobe.
- insert_addr_i  in  ADDR_BITS  line address to insert.
- insert_data_i  in  LINE_WIDTH  line data to insert.
- insert_dirty_i  in  1  dirty flag of the inserted line.
- insert_ready_o  out  1  insert accepted when high together with insert_req_i.
- wb_valid_o  out  1  write-back line pending.
- wb_ready_i  in  1  memory accepts the write-back.
- wb_addr_o  out  ADDR_BITS  write-back line address.
- wb_data_o  out  LINE_WIDTH  write-back line data.
- flush_i  in  1  flush request pulse.
- flush_done_o  out  1  one-cycle pulse when the flush completes.
- occupancy_o  out  $clog2(NUM_ENTRIES+1)  registered count of valid entries.

## Operation
- **States:**
  - IDLE.
  - WB_WAIT: one displaced line is held in the write-back register.
  - FLUSH_SCAN: index i walks 0..NUM_ENTRIES-1.
  - FLUSH_WB: a dirty entry is being written back.
  - FLUSH_DONE.
- **Lookup:**
  - Compares lookup_addr_i against all valid entries and against the write-back register while wb_valid_o is high.
  - A match in the write-back register returns lookup_dirty_o=0; that line is still written back.
  - Entries are unique, so at most one entry matches.
  - Lookups are serviced in every state.
- **Take:**
  - Honoured only in the cycle lookup_hit_o=1 and only if the hit came from an entry.
  - That entry's valid and dirty bits are cleared.
  - Take is ignored if the hit entry was overwritten by an insert in the lookup cycle.
- **Insert (when insert_req_i && insert_ready_o), slot selection in priority order:**
  1. The entry with the same address: overwrite it in place, dirty = old | new.
  2. The slot freed by a simultaneous take (swap).
  3. The lowest-index invalid entry.
  4. Otherwise the entry at rr_ptr; rr_ptr then increments, wrapping NUM_ENTRIES-1 → 0.
- **Displacement:** if the replaced entry (rule 4) is valid and dirty, its addr/data are copied into the write-back register in the same cycle the new line is written; state → WB_WAIT.
- **insert_ready_o** = (state==IDLE) && !flush_i.
- **WB_WAIT:**
  - wb_valid_o=1; wb_addr_o and wb_data_o stay stable until wb_ready_i.
  - On the handshake, go to IDLE, or to FLUSH_SCAN if a flush is latched.
- **Flush:**
  - flush_i is latched in any state and starts from IDLE.
  - Each valid+dirty entry is presented on the wb port in index order; each handshake clears that entry's dirty bit.
  - After index NUM_ENTRIES-1, all entries are invalidated and rr_ptr resets to 0.
  - FLUSH_DONE asserts flush_done_o for one cycle, then → IDLE.
  - A flush of a clean or empty buffer completes without using the wb port.
- **occupancy_o** reflects all inserts and takes of the previous cycle.

## Timing
- **Reset** (asynchronous, immediate): all valid and dirty bits, rr_ptr, the latched flush, every output and the pending write-back are cleared to 0; state = IDLE.
- **Lookup latency:** 1 cycle.
  - lookup_hit_o is 0 in any cycle not preceded by lookup_req_i.
  - lookup_data_o holds its last value.
- **Same-cycle lookup and insert to the same address:** the lookup sees the contents before the insert.
- **Insert timing:** the inserted line is visible to lookups issued the next cycle. A displaced dirty line raises wb_valid_o the next cycle.
- **Flush throughput:** FLUSH_SCAN spends 1 cycle per clean or invalid entry. A dirty entry costs 1 + (cycles waiting for wb_ready_i).
- **Minimum flush:** flush_done_o rises NUM_ENTRIES+2 cycles after flush_i on a clean buffer.

## Structure
- **Shared cache package** (alongside the existing cache defines):
  - VICTIM_NUM_ENTRIES, VICTIM_ADDR_BITS.
  - type_victim_entry_s {valid, dirty, addr}.
  - type_victim_state_e.
- **Line data storage:** a register array inside the block.
- **Sub-module victim_replace_sel** (combinational): receives valid vector, match vector, take slot and rr_ptr; returns the slot index and a displace flag. rr_ptr stays in the parent.

## Test plan
- **Basic hit:** insert 0x0000123 (clean, data A) into the empty buffer, then look up 0x0000123 → next cycle hit=1, data=A, dirty=0, occupancy=1; a lookup of 0x0000124 → hit=0.
- **Fill and round-robin:** insert 5 clean lines with NUM_ENTRIES=4 → the fifth replaces slot 0, rr_ptr=1, wb_valid_o stays 0, occupancy=4.
- **Dirty displacement:** with a full buffer, slot 0 dirty and holding 0x0000AAA/B, insert a new line → wb_valid_o=1 with addr 0x0000AAA and data B. Hold wb_ready_i low 3 cycles: insert_ready_o stays 0 and a lookup of 0x0000AAA hits with dirty=0. On handshake → IDLE.
- **Swap:** a lookup hits slot 2, then take_i plus an insert in the next cycle → new line lands in slot 2, no write-back, occupancy unchanged.
- **Flush:** entries 1 and 3 dirty → two wb handshakes in order 1, 3, then flush_done_o pulse and occupancy=0. On a clean buffer, flush_done_o arrives 6 cycles after flush_i.
- **Mid-operation reset:** assert rst_n=0 during WB_WAIT → wb_valid_o, lookup_hit_o and occupancy_o drop to 0 without waiting for a clock edge. After release, a lookup of any earlier address misses.
